// File: rtl/mul_div_result_buffer.sv
// -----------------------------------------------------------------------------
// mul_div_result_buffer
//
// Purpose:
//   A small FIFO that sits behind a mul_div unit. Each entry holds the result R
//   (2N bits) and its five exception flags. The head of the queue is always
//   shown on the outputs (first-word fall-through). When the FIFO cannot accept
//   a result, the result is discarded and the drop output pulses for one cycle.
//   An optional sticky exception register collects the flags of every result
//   that is accepted.
//
// Parameters:
//   N      operand width of the upstream mul_div; results are 2N bits wide
//   DEPTH  number of FIFO entries (a power of two, at least 2)
//
// Ports:
//   clk           clock; all state changes on the rising edge
//   arst          asynchronous reset, active-low
//   in_valid      upstream result and flags are valid this cycle
//   in_R          upstream result (2N bits)
//   in_flags      {io, dz, of, uf, i} flags, MSB first
//   in_ready      the buffer accepts in_valid this cycle
//   out_valid     the head entry is valid
//   out_R         result of the head entry
//   out_flags     flags of the head entry
//   out_ready     the consumer takes the head entry this cycle
//   count         number of occupied entries
//   drop          one-cycle pulse: a result was discarded
//   flag_clr      clears the sticky exception register
//   sticky_flags  OR of the flags of all accepted results since the last clear
//
// Build option:
//   MUL_DIV_STICKY_FLAGS_EN  when defined, includes the sticky exception
//                            register. When undefined, sticky_flags is tied to
//                            zero and flag_clr is ignored.
// -----------------------------------------------------------------------------
module mul_div_result_buffer #(
  parameter int N     = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     in_valid,
  input  logic [2*N-1:0]           in_R,
  input  logic [4:0]               in_flags,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [2*N-1:0]           out_R,
  output logic [4:0]               out_flags,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop,
  input  logic                     flag_clr,
  output logic [4:0]               sticky_flags
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * N + 5;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign in_ready  = (count < FULL) || out_ready;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head      = mem[rd_ptr];
  assign out_R     = head[EW-1:5];
  assign out_flags = head[4:0];

  // Storage array: written on push only, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_R, in_flags};
    end
  end

  // Pointers, occupancy and the drop pulse.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      drop <= in_valid && !in_ready;
    end
  end

`ifdef MUL_DIV_STICKY_FLAGS_EN
  logic [4:0] sticky_q;

  // A clear that coincides with a push keeps the new event rather than losing it.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      sticky_q <= '0;
    end else if (flag_clr) begin
      sticky_q <= push ? in_flags : 5'b0;
    end else if (push) begin
      sticky_q <= sticky_q | in_flags;
    end
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_flag_clr;

  assign unused_flag_clr = flag_clr;
  assign sticky_flags    = 5'b0;
`endif

endmodule

// File: tb/tb_mul_div_result_buffer.sv
module tb_mul_div_result_buffer;

  localparam int N     = 10;
  localparam int DEPTH = 4;

  logic        clk;
  logic        arst;
  logic        in_valid;
  logic [19:0] in_R;
  logic [4:0]  in_flags;
  logic        in_ready;
  logic        out_valid;
  logic [19:0] out_R;
  logic [4:0]  out_flags;
  logic        out_ready;
  logic [2:0]  count;
  logic        drop;
  logic        flag_clr;
  logic [4:0]  sticky_flags;

  int errors = 0;
  int checks = 0;

  mul_div_result_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .arst         (arst),
    .in_valid     (in_valid),
    .in_R         (in_R),
    .in_flags     (in_flags),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_R        (out_R),
    .out_flags    (out_flags),
    .out_ready    (out_ready),
    .count        (count),
    .drop         (drop),
    .flag_clr     (flag_clr),
    .sticky_flags (sticky_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #2;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", drop); end
    checks++; if (sticky_flags !== 5'b0) begin errors++; $display("FAIL reset_sticky got=%b exp=00000", sticky_flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    // Pushes during reset must be ignored.
    in_valid = 1'b1; in_R = 20'h00123; in_flags = 5'b11111;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_push_ignored_count got=%0d exp=0", count); end
    checks++; if (sticky_flags !== 5'b0) begin errors++; $display("FAIL reset_push_ignored_sticky got=%b exp=00000", sticky_flags); end
    in_valid = 1'b0; in_flags = 5'b0;
    arst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    in_R = 20'h00ABC; in_flags = 5'b00100; in_valid = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got=%b exp=0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_R !== 20'h00ABC) begin errors++; $display("FAIL single_out_R got=%h exp=00abc", out_R); end
    checks++; if (out_flags !== 5'b00100) begin errors++; $display("FAIL single_out_flags got=%b exp=00100", out_flags); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_pop_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [19:0] exp_r;
    in_flags = 5'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_R = 20'(i);
      #1;
      if (i == 5) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL overflow_in_ready_full got=%b exp=0", in_ready); end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL overflow_count got=%0d exp=4", count); end
    checks++; if (drop !== 1'b1) begin errors++; $display("FAIL overflow_drop_pulse got=%b exp=1", drop); end
    @(posedge clk); #1;
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL overflow_drop_end got=%b exp=0", drop); end
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      exp_r = 20'(k);
      #1;
      checks++; if (out_R !== exp_r) begin errors++; $display("FAIL overflow_drain_%0d got=%h exp=%h", k, out_R, exp_r); end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL overflow_empty got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp_r;
    in_flags = 5'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_R = 20'(10 + i);
      @(posedge clk); #1;
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL b2b_fill_count got=%0d exp=4", count); end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_R = 20'(14 + k);
      exp_r = 20'(10 + k);
      #1;
      checks++; if (out_R !== exp_r) begin errors++; $display("FAIL b2b_out_%0d got=%h exp=%h", k, out_R, exp_r); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_%0d got=%b exp=1", k, in_ready); end
      @(posedge clk); #1;
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL b2b_count_%0d got=%0d exp=4", k, count); end
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL b2b_drop_%0d got=%b exp=0", k, drop); end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_r = 20'(18 + k);
      #1;
      checks++; if (out_R !== exp_r) begin errors++; $display("FAIL b2b_drain_%0d got=%h exp=%h", k, out_R, exp_r); end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_empty got=%0d exp=0", count); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_R = 20'(32'h31 + i); in_flags = 5'b00010;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_flags = 5'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL areset_pre_count got=%0d exp=3", count); end
    @(posedge clk); #3;
    arst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", count); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL areset_drop got=%b exp=0", drop); end
    checks++; if (sticky_flags !== 5'b0) begin errors++; $display("FAIL areset_sticky got=%b exp=00000", sticky_flags); end
    @(posedge clk); #1;
    arst = 1'b1;
    in_valid = 1'b1; in_R = 20'h00777; in_flags = 5'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_R !== 20'h00777) begin errors++; $display("FAIL areset_first_out got=%h exp=00777", out_R); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL areset_post_count got=%0d exp=1", count); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

`ifdef MUL_DIV_STICKY_FLAGS_EN
  task automatic test_sticky();
    in_valid = 1'b1; in_R = 20'h1; in_flags = 5'b01000;
    @(posedge clk); #1;
    in_flags = 5'b00001;
    @(posedge clk); #1;
    checks++; if (sticky_flags !== 5'b01001) begin errors++; $display("FAIL sticky_accum got=%b exp=01001", sticky_flags); end
    in_flags = 5'b10000; flag_clr = 1'b1;
    @(posedge clk); #1;
    checks++; if (sticky_flags !== 5'b10000) begin errors++; $display("FAIL sticky_clr_push got=%b exp=10000", sticky_flags); end
    in_valid = 1'b0; in_flags = 5'b0;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    checks++; if (sticky_flags !== 5'b0) begin errors++; $display("FAIL sticky_clr got=%b exp=00000", sticky_flags); end
    // Fourth entry fills the FIFO; the next push is dropped.
    in_valid = 1'b1; in_flags = 5'b0;
    @(posedge clk); #1;
    in_flags = 5'b00010;
    @(posedge clk); #1;
    in_valid = 1'b0; in_flags = 5'b0;
    checks++; if (drop !== 1'b1) begin errors++; $display("FAIL sticky_drop_pulse got=%b exp=1", drop); end
    checks++; if (sticky_flags !== 5'b0) begin errors++; $display("FAIL sticky_drop_ignored got=%b exp=00000", sticky_flags); end
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL sticky_drain got=%0d exp=0", count); end
  endtask
`else
  task automatic test_sticky();
    in_valid = 1'b1; in_R = 20'h5; in_flags = 5'b11111;
    @(posedge clk); #1;
    in_valid = 1'b0; in_flags = 5'b0;
    checks++; if (sticky_flags !== 5'b0) begin errors++; $display("FAIL sticky_off_push got=%b exp=00000", sticky_flags); end
    checks++; if (out_flags !== 5'b11111) begin errors++; $display("FAIL sticky_off_out_flags got=%b exp=11111", out_flags); end
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    checks++; if (sticky_flags !== 5'b0) begin errors++; $display("FAIL sticky_off_clr got=%b exp=00000", sticky_flags); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL sticky_off_count got=%0d exp=1", count); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL sticky_off_drain got=%0d exp=0", count); end
  endtask
`endif

  initial begin
    arst = 1'b0; in_valid = 1'b0; in_R = '0; in_flags = '0;
    out_ready = 1'b0; flag_clr = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_sticky();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
